// File: rtl/forward_unit_sb.sv
// EX-stage operand forwarder (ME / WB / drain-hold buffer) with a long-latency
// register scoreboard that generates the ID stall.
module forward_unit_sb #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int NUM_RD     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int MAX_PEND   = 4,
  localparam int CW        = $clog2(MAX_PEND + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_stall,
  input  logic [NUM_RD*AW-1:0]     id_rs_addr,
  input  logic [NUM_RD-1:0]        id_rs_used,
  input  logic [AW-1:0]            id_rd_addr,
  input  logic                     id_reg_we,
  input  logic                     id_is_long,
  input  logic [NUM_RD*AW-1:0]     ex_rs_addr,
  input  logic [NUM_RD*XLEN-1:0]   ex_rs_data,
  input  logic [AW-1:0]            ex_rd_addr,
  input  logic                     ex_reg_we,
  input  logic                     ex_is_load,
  input  logic                     lq_issue,
  input  logic                     lc_valid,
  input  logic [AW-1:0]            lc_addr,
  input  logic                     me_reg_we,
  input  logic [AW-1:0]            me_rd_addr,
  input  logic [XLEN-1:0]          me_data,
  input  logic                     wb_reg_we,
  input  logic [AW-1:0]            wb_rd_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic [NUM_RD*XLEN-1:0]   ex_fwd_data,
  output logic [NUM_RD*2-1:0]      ex_fwd_sel,
  output logic                     stall_id,
  output logic [CW-1:0]            pend_cnt,
  output logic                     pend_full
);

  // Hold entry 0 is the newest; valid entries always form a contiguous prefix.
  logic [HOLD_DEPTH-1:0]           hv_q, hv_d;
  logic [HOLD_DEPTH-1:0][AW-1:0]   ha_q, ha_d;
  logic [HOLD_DEPTH-1:0][XLEN-1:0] hd_q, hd_d;
  logic                            hold_hit;

  logic [2**AW-1:0] pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             issue_ok, comp_ok;

  always_comb begin
    hv_d     = hv_q;
    ha_d     = ha_q;
    hd_d     = hd_q;
    hold_hit = 1'b0;
    if (!pipe_stall) begin
      hv_d = '0;
    end else if (wb_reg_we && wb_rd_addr != '0) begin
      for (int j = 0; j < HOLD_DEPTH; j++) begin
        if (hv_q[j] && ha_q[j] == wb_rd_addr) begin
          hold_hit = 1'b1;
          hd_d[j]  = wb_data;
        end
      end
      if (!hold_hit) begin
        for (int k = HOLD_DEPTH - 1; k > 0; k--) begin
          hv_d[k] = hv_q[k-1];
          ha_d[k] = ha_q[k-1];
          hd_d[k] = hd_q[k-1];
        end
        hv_d[0] = 1'b1;
        ha_d[0] = wb_rd_addr;
        hd_d[0] = wb_data;
      end
    end
  end

  always_comb begin
    ex_fwd_data = ex_rs_data;
    ex_fwd_sel  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ex_rs_addr[i*AW +: AW] != '0) begin
        if (me_reg_we && me_rd_addr == ex_rs_addr[i*AW +: AW]) begin
          ex_fwd_sel[i*2 +: 2]     = 2'd1;
          ex_fwd_data[i*XLEN +: XLEN] = me_data;
        end else if (wb_reg_we && wb_rd_addr == ex_rs_addr[i*AW +: AW]) begin
          ex_fwd_sel[i*2 +: 2]     = 2'd2;
          ex_fwd_data[i*XLEN +: XLEN] = wb_data;
        end else begin
          // Walk oldest to newest so the newest match wins.
          for (int j = HOLD_DEPTH - 1; j >= 0; j--) begin
            if (hv_q[j] && ha_q[j] == ex_rs_addr[i*AW +: AW]) begin
              ex_fwd_sel[i*2 +: 2]     = 2'd3;
              ex_fwd_data[i*XLEN +: XLEN] = hd_q[j];
            end
          end
        end
      end
    end
  end

  assign issue_ok = lq_issue && !pipe_stall && ex_rd_addr != '0;
  assign comp_ok  = lc_valid && pend_q[lc_addr];

  always_comb begin
    pend_d = pend_q;
    if (lc_valid) pend_d[lc_addr] = 1'b0;
    if (issue_ok) pend_d[ex_rd_addr] = 1'b1;
    cnt_d = cnt_q;
    if (issue_ok && !comp_ok && cnt_q != CW'(MAX_PEND)) cnt_d = cnt_q + 1'b1;
    else if (comp_ok && !issue_ok && cnt_q != '0)       cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hv_q   <= '0;
      ha_q   <= '0;
      hd_q   <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      hv_q   <= hv_d;
      ha_q   <= ha_d;
      hd_q   <= hd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt  = cnt_q;
  assign pend_full = (cnt_q == CW'(MAX_PEND));

  always_comb begin
    stall_id = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (id_rs_used[i]) begin
        if (ex_reg_we && ex_is_load && ex_rd_addr != '0 &&
            ex_rd_addr == id_rs_addr[i*AW +: AW])
          stall_id = 1'b1;
        // A completion in the same cycle releases the reader immediately.
        if (id_rs_addr[i*AW +: AW] != '0 && pend_q[id_rs_addr[i*AW +: AW]] &&
            !(lc_valid && lc_addr == id_rs_addr[i*AW +: AW]))
          stall_id = 1'b1;
      end
    end
    if (id_reg_we && id_rd_addr != '0 && pend_q[id_rd_addr]) stall_id = 1'b1;
    if (id_is_long && pend_full) stall_id = 1'b1;
  end

endmodule

// File: tb/tb_forward_unit_sb.sv
// Directed bench for forward_unit_sb: vector table for the combinational
// forwarding/load-use paths, hand sequences for hold buffer and scoreboard.
module tb_forward_unit_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_stall;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd_addr;
  logic        id_reg_we, id_is_long;
  logic [9:0]  ex_rs_addr;
  logic [63:0] ex_rs_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_we, ex_is_load, lq_issue, lc_valid;
  logic [4:0]  lc_addr;
  logic        me_reg_we;
  logic [4:0]  me_rd_addr;
  logic [31:0] me_data;
  logic        wb_reg_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic [63:0] ex_fwd_data;
  logic [3:0]  ex_fwd_sel;
  logic        stall_id;
  logic [2:0]  pend_cnt;
  logic        pend_full;

  int n_vec = 0;
  int n_bad = 0;

  forward_unit_sb dut (
    .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr),
    .id_reg_we(id_reg_we), .id_is_long(id_is_long),
    .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
    .lq_issue(lq_issue), .lc_valid(lc_valid), .lc_addr(lc_addr),
    .me_reg_we(me_reg_we), .me_rd_addr(me_rd_addr), .me_data(me_data),
    .wb_reg_we(wb_reg_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_fwd_data(ex_fwd_data), .ex_fwd_sel(ex_fwd_sel), .stall_id(stall_id),
    .pend_cnt(pend_cnt), .pend_full(pend_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  rs;
    logic [63:0] rsd;
    logic        me_we;
    logic [4:0]  me_a;
    logic [31:0] me_d;
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic [9:0]  id_rs;
    logic [1:0]  id_used;
    logic        ex_we;
    logic        ex_ld;
    logic [4:0]  ex_rd;
    logic [3:0]  e_sel;
    logic [63:0] e_data;
    logic        e_stall;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_stall = 0; id_rs_addr = '0; id_rs_used = '0; id_rd_addr = '0;
    id_reg_we = 0; id_is_long = 0; ex_rs_addr = '0; ex_rs_data = '0;
    ex_rd_addr = '0; ex_reg_we = 0; ex_is_load = 0; lq_issue = 0;
    lc_valid = 0; lc_addr = '0; me_reg_we = 0; me_rd_addr = '0; me_data = '0;
    wb_reg_we = 0; wb_rd_addr = '0; wb_data = '0;
  endtask

  initial begin
    vt[0] = '{{5'd5,5'd0}, {32'hBBBB_0002,32'hCAFE_0000}, 1,5'd5,32'hAAAA_0001, 1,5'd0,32'h1234,
              10'd0,2'b00, 0,0,5'd0, 4'b0100, {32'hAAAA_0001,32'hCAFE_0000}, 0};
    vt[1] = '{{5'd7,5'd7}, {32'd1,32'd2}, 1,5'd7,32'h11, 1,5'd7,32'h22,
              10'd0,2'b00, 0,0,5'd0, 4'b0101, {32'h11,32'h11}, 0};
    vt[2] = '{{5'd7,5'd7}, {32'd1,32'd2}, 0,5'd7,32'h11, 1,5'd7,32'h22,
              10'd0,2'b00, 0,0,5'd0, 4'b1010, {32'h22,32'h22}, 0};
    vt[3] = '{{5'd7,5'd7}, {32'd1,32'd2}, 0,5'd7,32'h11, 0,5'd7,32'h22,
              10'd0,2'b00, 0,0,5'd0, 4'b0000, {32'd1,32'd2}, 0};
    vt[4] = '{{5'd9,5'd8}, {32'h99,32'h88}, 1,5'd8,32'h800, 1,5'd9,32'h900,
              10'd0,2'b00, 0,0,5'd0, 4'b1001, {32'h900,32'h800}, 0};
    vt[5] = '{{5'd0,5'd0}, {32'd3,32'd4}, 0,5'd0,32'h0, 0,5'd0,32'h0,
              {5'd9,5'd3},2'b10, 1,1,5'd9, 4'b0000, {32'd3,32'd4}, 1};
    vt[6] = '{{5'd0,5'd0}, {32'd3,32'd4}, 0,5'd0,32'h0, 0,5'd0,32'h0,
              {5'd9,5'd3},2'b01, 1,1,5'd9, 4'b0000, {32'd3,32'd4}, 0};
    vt[7] = '{{5'd0,5'd0}, {32'd3,32'd4}, 0,5'd0,32'h0, 0,5'd0,32'h0,
              {5'd0,5'd9},2'b01, 1,1,5'd9, 4'b0000, {32'd3,32'd4}, 1};
    vt[8] = '{{5'd0,5'd0}, {32'd3,32'd4}, 0,5'd0,32'h0, 0,5'd0,32'h0,
              {5'd0,5'd9},2'b01, 1,0,5'd9, 4'b0000, {32'd3,32'd4}, 0};
    vt[9] = '{{5'd0,5'd0}, {32'd3,32'd4}, 0,5'd0,32'h0, 0,5'd0,32'h0,
              {5'd0,5'd0},2'b11, 1,1,5'd0, 4'b0000, {32'd3,32'd4}, 0};

    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #2;
    chk("reset_sel", {60'd0, ex_fwd_sel}, 64'd0);
    chk("reset_cnt", {61'd0, pend_cnt}, 64'd0);
    chk("reset_full", {63'd0, pend_full}, 64'd0);
    chk("reset_stall", {63'd0, stall_id}, 64'd0);

    for (int v = 0; v < 10; v++) begin
      step();
      idle();
      ex_rs_addr = vt[v].rs;  ex_rs_data = vt[v].rsd;
      me_reg_we = vt[v].me_we; me_rd_addr = vt[v].me_a; me_data = vt[v].me_d;
      wb_reg_we = vt[v].wb_we; wb_rd_addr = vt[v].wb_a; wb_data = vt[v].wb_d;
      id_rs_addr = vt[v].id_rs; id_rs_used = vt[v].id_used;
      ex_reg_we = vt[v].ex_we; ex_is_load = vt[v].ex_ld; ex_rd_addr = vt[v].ex_rd;
      #2;
      chk($sformatf("vec%0d_sel", v), {60'd0, ex_fwd_sel}, {60'd0, vt[v].e_sel});
      chk($sformatf("vec%0d_data", v), ex_fwd_data, vt[v].e_data);
      chk($sformatf("vec%0d_stall", v), {63'd0, stall_id}, {63'd0, vt[v].e_stall});
    end

    // Drain-hold: x3, x4, x3 again (in-place), then x6 evicts oldest (x3).
    step(); idle();
    pipe_stall = 1; wb_reg_we = 1; wb_rd_addr = 5'd3; wb_data = 32'h10;
    step(); wb_rd_addr = 5'd4; wb_data = 32'h20;
    step(); wb_rd_addr = 5'd3; wb_data = 32'h30;
    step(); wb_reg_we = 0;
    ex_rs_addr = {5'd4,5'd3}; ex_rs_data = {32'hF4,32'hF3};
    #2;
    chk("hold_sel", {60'd0, ex_fwd_sel}, 64'hF);
    chk("hold_data", ex_fwd_data, {32'h20,32'h30});
    wb_reg_we = 1; wb_rd_addr = 5'd6; wb_data = 32'h60;
    step(); wb_reg_we = 0;
    #2;
    chk("evict_sel", {60'd0, ex_fwd_sel}, 64'hC);
    chk("evict_data", ex_fwd_data, {32'h20,32'hF3});
    pipe_stall = 0;
    step();
    #2;
    chk("hold_clr_sel", {60'd0, ex_fwd_sel}, 64'd0);
    chk("hold_clr_data", ex_fwd_data, {32'hF4,32'hF3});

    // Priority including hold.
    pipe_stall = 1; wb_reg_we = 1; wb_rd_addr = 5'd7; wb_data = 32'h33;
    step(); wb_reg_we = 0;
    ex_rs_addr = {5'd0,5'd7}; ex_rs_data = {32'h0,32'hF7};
    #2;
    chk("prio_hold", {ex_fwd_sel, ex_fwd_data[31:0]}, {4'b0011, 32'h33});
    wb_reg_we = 1; wb_data = 32'h22;
    #1;
    chk("prio_wb", {ex_fwd_sel, ex_fwd_data[31:0]}, {4'b0010, 32'h22});
    me_reg_we = 1; me_rd_addr = 5'd7; me_data = 32'h11;
    #1;
    chk("prio_me", {ex_fwd_sel, ex_fwd_data[31:0]}, {4'b0001, 32'h11});
    step(); idle(); step();

    // Scoreboard: single long op to x12.
    ex_rd_addr = 5'd12; lq_issue = 1;
    step(); idle();
    #2;
    chk("sb_cnt1", {61'd0, pend_cnt}, 64'd1);
    id_rs_addr = {5'd0,5'd12}; id_rs_used = 2'b01;
    #1;
    chk("sb_raw", {63'd0, stall_id}, 64'd1);
    id_rs_used = 2'b00; id_reg_we = 1; id_rd_addr = 5'd12;
    #1;
    chk("sb_waw", {63'd0, stall_id}, 64'd1);
    id_reg_we = 0; id_rs_used = 2'b01;
    pipe_stall = 1; lq_issue = 1; ex_rd_addr = 5'd13;
    step(); pipe_stall = 0; lq_issue = 0;
    #2;
    chk("sb_raw_hold", {63'd0, stall_id}, 64'd1);
    chk("sb_frozen_issue", {61'd0, pend_cnt}, 64'd1);
    lc_valid = 1; lc_addr = 5'd12;
    #1;
    chk("sb_lc_same", {63'd0, stall_id}, 64'd0);
    step(); lc_valid = 0;
    #2;
    chk("sb_cnt0", {61'd0, pend_cnt}, 64'd0);
    chk("sb_after", {63'd0, stall_id}, 64'd0);
    idle();

    // Budget: fill x1..x4.
    for (int r = 1; r <= 4; r++) begin
      lq_issue = 1; ex_rd_addr = 5'(r);
      step();
    end
    idle();
    #2;
    chk("bud_cnt", {61'd0, pend_cnt}, 64'd4);
    chk("bud_full", {63'd0, pend_full}, 64'd1);
    id_is_long = 1;
    #1;
    chk("bud_stall", {63'd0, stall_id}, 64'd1);
    id_is_long = 0;
    #1;
    chk("bud_nolong", {63'd0, stall_id}, 64'd0);
    lq_issue = 1; ex_rd_addr = 5'd5; lc_valid = 1; lc_addr = 5'd1;
    step(); idle();
    #2;
    chk("bud_swap_cnt", {61'd0, pend_cnt}, 64'd4);
    id_rs_addr = {5'd1,5'd5}; id_rs_used = 2'b01;
    #1;
    chk("bud_raw_x5", {63'd0, stall_id}, 64'd1);
    id_rs_used = 2'b10;
    #1;
    chk("bud_x1_free", {63'd0, stall_id}, 64'd0);
    lc_valid = 1; lc_addr = 5'd20;
    step(); lc_valid = 0;
    #2;
    chk("bud_ghost_lc", {61'd0, pend_cnt}, 64'd4);
    rst_n = 0;
    step(); rst_n = 1;
    id_is_long = 1; id_rs_used = 2'b01;
    #2;
    chk("rst_cnt", {61'd0, pend_cnt}, 64'd0);
    chk("rst_full", {63'd0, pend_full}, 64'd0);
    chk("rst_stall", {63'd0, stall_id}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
